alu16_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared 16-bit ALU datapath (alu16).
- Accepts operation requests (operator, op1, op2) over valid/ready handshakes.
- Grants one requester, drives the ALU from registered operands, and captures the result.
- Returns the result with an error flag to the granted requester over a valid/ready response handshake.
- Sits between the instruction-issue logic / coprocessor ports and the single alu16 instance.

---
 rtl/alu16_pkg.sv | 31 +++
 rtl/alu16.sv | 36 +++
 rtl/rr_pick2.sv | 21 ++
 rtl/alu16_arbiter.sv | 130 +++++++++++++
 tb/tb_alu16_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu16_pkg.sv
// Shared definitions for the alu16 datapath and its request arbiter.
//   ALU_W / ALU_OPW : operand and operator-code widths of alu16.
//   ALU_*           : operator codes understood by alu16.
//   ST_*            : arbiter FSM state encodings (IDLE -> EXEC -> DONE).
//   op_is_error     : operations whose response carries the error flag.
package alu16_pkg;

  localparam int ALU_W   = 16;
  localparam int ALU_OPW = 4;
  localparam int ALU_DW  = 2 * ALU_W;  // full-width ALU output (product)

  localparam logic [ALU_OPW-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OPW-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OPW-1:0] ALU_MUL  = 4'd2;
  localparam logic [ALU_OPW-1:0] ALU_NAND = 4'd3;
  localparam logic [ALU_OPW-1:0] ALU_DIV  = 4'd4;
  localparam logic [ALU_OPW-1:0] ALU_MOD  = 4'd5;
  localparam logic [ALU_OPW-1:0] ALU_LT   = 4'd6;
  localparam logic [ALU_OPW-1:0] ALU_LE   = 4'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Division by zero and any code above ALU_LE cannot produce a result.
  function automatic logic op_is_error(input logic [ALU_OPW-1:0] op,
                                       input logic [ALU_W-1:0]   b);
    return (((op == ALU_DIV) || (op == ALU_MOD)) && (b == '0)) || (op > ALU_LE);
  endfunction

endpackage

// File: rtl/alu16.sv
// alu16: combinational 16-bit ALU.
//   rst      in  active-low reset; forces out to zero while asserted
//   operator in  operation code (ALU_* from alu16_pkg)
//   op1/op2  in  16-bit operands
//   out      out 32-bit result (products use the full width; others zero-extended)
// Division/modulo by zero and unknown codes yield zero.
module alu16
  import alu16_pkg::*;
(
  input  logic               rst,
  input  logic [ALU_OPW-1:0] operator,
  input  logic [ALU_W-1:0]   op1,
  input  logic [ALU_W-1:0]   op2,
  output logic [ALU_DW-1:0]  out
);

  localparam logic [ALU_W-1:0] ZERO_HI = '0;

  always_comb begin
    out = '0;
    if (rst) begin
      case (operator)
        ALU_ADD:  out = ALU_DW'(op1) + ALU_DW'(op2);
        ALU_SUB:  out = {ZERO_HI, op1 - op2};
        ALU_MUL:  out = ALU_DW'(op1) * ALU_DW'(op2);
        ALU_NAND: out = {ZERO_HI, ~(op1 & op2)};
        ALU_DIV:  out = (op2 == '0) ? '0 : {ZERO_HI, op1 / op2};
        ALU_MOD:  out = (op2 == '0) ? '0 : {ZERO_HI, op1 % op2};
        ALU_LT:   out = {{(ALU_DW-1){1'b0}}, (op1 <  op2)};
        ALU_LE:   out = {{(ALU_DW-1){1'b0}}, (op1 <= op2)};
        default:  out = '0;
      endcase
    end
  end

endmodule

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker.
//   valid in  request valid per requester
//   ptr   in  requester favoured when both are valid
//   gnt   out one-hot grant, zero when nothing is valid
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (valid)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu16_arbiter.sv
// alu16_arbiter: two-requester round-robin sequencer for a single alu16.
//   clk        in  system clock, rising edge
//   rst        in  asynchronous active-low reset
//   req_valid  in  [1:0] request valid, bit i = requester i
//   req_ready  out [1:0] accept strobe, one-hot or zero, only in IDLE
//   req_op     in  [2*OPW-1:0]   operator, requester i at [i*OPW +: OPW]
//   req_a      in  [2*WIDTH-1:0] op1, requester i at [i*WIDTH +: WIDTH]
//   req_b      in  [2*WIDTH-1:0] op2, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid  out [1:0] response valid, one-hot or zero, only in DONE
//   rsp_ready  in  [1:0] response accept; only the granted bit matters
//   rsp_data   out [WIDTH-1:0] result (ERR_RESULT when rsp_err)
//   rsp_err    out error flag (divide by zero, illegal operator)
//   busy       out high whenever the FSM is not IDLE
//   dbg_state  out [1:0] current FSM state (ST_* encodings)
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high at the rising edge. req_ready is a combinational response to
// req_valid in IDLE; rsp_valid is held with stable data until rsp_ready.
// One operation takes at least three cycles (IDLE, EXEC, DONE).
module alu16_arbiter
  import alu16_pkg::*;
#(
  parameter int               WIDTH      = ALU_W,   // must match alu16
  parameter int               OPW        = ALU_OPW, // must match alu16
  parameter logic [WIDTH-1:0] ERR_RESULT = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*OPW-1:0]   req_op,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  logic [1:0]        state_q;
  logic              ptr_q;     // requester favoured on a tie
  logic              grant_q;   // requester owning the current operation
  logic [OPW-1:0]    op_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  result_q;
  logic              err_q;

  logic [1:0]        pick;
  logic              win;
  logic [OPW-1:0]    win_op;
  logic [WIDTH-1:0]  win_a;
  logic [WIDTH-1:0]  win_b;
  logic [ALU_DW-1:0] alu_out;
  logic              exec_err;
  logic              rsp_fire;

  rr_pick2 u_pick (
    .valid (req_valid),
    .ptr   (ptr_q),
    .gnt   (pick)
  );

  alu16 u_alu (
    .rst      (rst),
    .operator (op_q),
    .op1      (a_q),
    .op2      (b_q),
    .out      (alu_out)
  );

  // Operand mux for the winning requester.
  assign win    = pick[1];
  assign win_op = win ? req_op[OPW +: OPW]     : req_op[0 +: OPW];
  assign win_a  = win ? req_a[WIDTH +: WIDTH]  : req_a[0 +: WIDTH];
  assign win_b  = win ? req_b[WIDTH +: WIDTH]  : req_b[0 +: WIDTH];

  assign exec_err = op_is_error(op_q, b_q);
  assign rsp_fire = (state_q == ST_DONE) && rsp_ready[grant_q];

  // Gated by rst so no accept strobe is seen while reset is held.
  assign req_ready = (rst && (state_q == ST_IDLE)) ? pick : 2'b00;
  assign rsp_valid = (state_q == ST_DONE) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data  = result_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 1'b0;
      grant_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick != 2'b00) begin
            op_q    <= win_op;
            a_q     <= win_a;
            b_q     <= win_b;
            grant_q <= win;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Product keeps only its low WIDTH bits; no overflow reporting.
          result_q <= exec_err ? ERR_RESULT : alu_out[WIDTH-1:0];
          err_q    <= exec_err;
          state_q  <= ST_DONE;
        end
        ST_DONE: begin
          // Pointer moves only on completion so persistent requesters alternate.
          if (rsp_fire) begin
            ptr_q   <= ~grant_q;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu16_arbiter.sv
module tb_alu16_arbiter;
  import alu16_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [7:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b00;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  alu16_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int m_ptr = 0;            // reference model: favoured requester on a tie
  logic [15:0] exp_q[$];    // scoreboard: expected response data
  logic        exp_err_q[$];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, summary forced");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Returns {err, data} from the arithmetic definition of each operator.
  function automatic logic [16:0] model_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] r;
    logic e;
    r = 0;
    e = 0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a * b;
      4'd3: r = ~(a & b);
      4'd4: if (b == 0) e = 1; else r = a / b;
      4'd5: if (b == 0) e = 1; else r = a % b;
      4'd6: r = (a < b) ? 32'd1 : 32'd0;
      4'd7: r = (a <= b) ? 32'd1 : 32'd0;
      default: e = 1;
    endcase
    if (e) r = 0;
    return {e, r[15:0]};
  endfunction

  function automatic int model_pick(input logic [1:0] v);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    return m_ptr;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    tick();
    tick();
    rst = 1'b1;
    m_ptr = 0;
    tick();
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    req_op[i*4 +: 4]  = op;
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
  endtask

  // One full transaction: request, wait for response, optionally hold
  // rsp_ready low (while poking the non-granted rsp_ready bit), then accept.
  task automatic do_txn(input logic [1:0] vmask, input bit keep, input int hold,
                        output logic [1:0] rr, output logic [1:0] rv,
                        output logic [15:0] data, output logic err,
                        output int lat, output logic stable, output bit tmo);
    int c;
    int g;
    logic [15:0] d0;
    logic e0;
    tmo = 0; rr = 0; rv = 0; data = 0; err = 0; lat = 0; stable = 1;
    req_valid = vmask;
    rsp_ready = 2'b00;
    #1;
    c = 0;
    while (req_ready == 2'b00 && c < 20) begin
      tick();
      c++;
    end
    rr = req_ready;
    if (rr == 2'b00) begin
      tmo = 1;
      req_valid = 2'b00;
      return;
    end
    g = rr[1] ? 1 : 0;
    tick();
    lat = 1;
    if (!keep) begin
      req_valid = 2'b00;
      req_op = 8'($urandom);
      req_a = $urandom;
      req_b = $urandom;
    end
    while (rsp_valid == 2'b00 && lat < 20) begin
      tick();
      lat++;
    end
    rv = rsp_valid;
    if (rv == 2'b00) begin
      tmo = 1;
      return;
    end
    d0 = rsp_data;
    e0 = rsp_err;
    for (int h = 0; h < hold; h++) begin
      rsp_ready = (g == 1) ? 2'b01 : 2'b10;
      tick();
      if (rsp_valid != rv || rsp_data != d0 || rsp_err != e0 || busy != 1'b1 || req_ready != 2'b00)
        stable = 0;
    end
    data = rsp_data;
    err = rsp_err;
    rsp_ready = (g == 1) ? 2'b10 : 2'b01;
    tick();
    rsp_ready = 2'b00;
    m_ptr = 1 - g;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    req_valid = 2'b11;
    #1;
    n_cmp++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_data !== 16'h0000 || rsp_err !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rr=%b rv=%b data=%h err=%b busy=%b, want all zero",
               req_ready, rsp_valid, rsp_data, rsp_err, busy);
    end
    n_cmp++;
    if (dbg_state !== ST_IDLE) begin
      n_bad++;
      $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
    end
    apply_reset();
  endtask

  task automatic test_single();
    logic [1:0] rr, rv; logic [15:0] d; logic e, st; int lat; bit tmo;
    set_req(0, ALU_ADD, 16'h0003, 16'h0004);
    do_txn(2'b01, 0, 0, rr, rv, d, e, lat, st, tmo);
    n_cmp++;
    if (tmo !== 1'b0) begin n_bad++; $display("FAIL single_timeout: got timeout=1 want 0"); end
    n_cmp++;
    if (rr !== 2'b01 || rv !== 2'b01) begin
      n_bad++; $display("FAIL single_grant: got rr=%b rv=%b want 01/01", rr, rv);
    end
    n_cmp++;
    if (lat != 2) begin n_bad++; $display("FAIL single_latency: got %0d want 2", lat); end
    n_cmp++;
    if (d !== 16'h0007 || e !== 1'b0) begin
      n_bad++; $display("FAIL single_data: got %h err=%b want 0007 err=0", d, e);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] rr, rv; logic [15:0] d; logic e, st; int lat; bit tmo;
    logic [1:0] want_g;
    logic [15:0] want_d;
    apply_reset();
    set_req(0, ALU_SUB, 16'd10, 16'd3);
    set_req(1, ALU_MUL, 16'h0100, 16'h0100);
    for (int k = 0; k < 4; k++) begin
      want_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      want_d = (k % 2 == 0) ? 16'h0007 : 16'h0000;
      do_txn(2'b11, 1, 0, rr, rv, d, e, lat, st, tmo);
      n_cmp++;
      if (tmo !== 1'b0 || rr !== want_g || rv !== want_g) begin
        n_bad++; $display("FAIL fair_grant[%0d]: got rr=%b rv=%b tmo=%b want %b", k, rr, rv, tmo, want_g);
      end
      n_cmp++;
      if (d !== want_d || e !== 1'b0) begin
        n_bad++; $display("FAIL fair_data[%0d]: got %h err=%b want %h err=0", k, d, e, want_d);
      end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_errors();
    logic [1:0] rr, rv; logic [15:0] d; logic e, st; int lat; bit tmo;
    int          who[5]   = '{1, 1, 0, 0, 0};
    logic [3:0]  ops[5]   = '{ALU_DIV, ALU_MOD, 4'hA, ALU_LT, ALU_LE};
    logic [15:0] as[5]    = '{16'h0009, 16'h0009, 16'h1234, 16'h0002, 16'h0005};
    logic [15:0] bs[5]    = '{16'h0000, 16'h0004, 16'h0001, 16'h0005, 16'h0002};
    logic [15:0] wd[5]    = '{16'h0000, 16'h0001, 16'h0000, 16'h0001, 16'h0000};
    logic        we[5]    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  m;
    for (int k = 0; k < 5; k++) begin
      set_req(who[k], ops[k], as[k], bs[k]);
      m = (who[k] == 1) ? 2'b10 : 2'b01;
      do_txn(m, 0, 0, rr, rv, d, e, lat, st, tmo);
      n_cmp++;
      if (tmo !== 1'b0 || rv !== m) begin
        n_bad++; $display("FAIL err_grant[%0d]: got rv=%b tmo=%b want %b", k, rv, tmo, m);
      end
      n_cmp++;
      if (d !== wd[k] || e !== we[k]) begin
        n_bad++; $display("FAIL err_data[%0d]: got %h err=%b want %h err=%b", k, d, e, wd[k], we[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    set_req(0, ALU_ADD, 16'h0001, 16'h0002);
    set_req(1, ALU_SUB, 16'h0009, 16'h0004);
    req_valid = 2'b01;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin n_bad++; $display("FAIL bp_accept0: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b10;
    #1;
    n_cmp++;
    if (req_ready !== 2'b00 || busy !== 1'b1) begin
      n_bad++; $display("FAIL bp_exec_ready: got rr=%b busy=%b want 00/1", req_ready, busy);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 2'b01 || rsp_data !== 16'h0003 || rsp_err !== 1'b0) begin
      n_bad++; $display("FAIL bp_rsp0: got rv=%b data=%h err=%b want 01/0003/0", rsp_valid, rsp_data, rsp_err);
    end
    for (int h = 0; h < 5; h++) begin
      tick();
      n_cmp++;
      if (rsp_valid !== 2'b01 || rsp_data !== 16'h0003 || busy !== 1'b1 || req_ready !== 2'b00) begin
        n_bad++; $display("FAIL bp_hold[%0d]: got rv=%b data=%h busy=%b rr=%b want 01/0003/1/00",
                          h, rsp_valid, rsp_data, busy, req_ready);
      end
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    n_cmp++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b10) begin
      n_bad++; $display("FAIL bp_release: got busy=%b rv=%b rr=%b want 0/00/10", busy, rsp_valid, req_ready);
    end
    tick();
    req_valid = 2'b00;
    tick();
    n_cmp++;
    if (rsp_valid !== 2'b10 || rsp_data !== 16'h0005 || rsp_err !== 1'b0) begin
      n_bad++; $display("FAIL bp_rsp1: got rv=%b data=%h err=%b want 10/0005/0", rsp_valid, rsp_data, rsp_err);
    end
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    m_ptr = 0;
  endtask

  task automatic test_reset_mid();
    logic [1:0] rr, rv; logic [15:0] d; logic e, st; int lat; bit tmo;
    logic seen;
    apply_reset();
    set_req(0, ALU_ADD, 16'h0001, 16'h0001);
    do_txn(2'b01, 0, 0, rr, rv, d, e, lat, st, tmo);   // pointer now favours requester 1
    set_req(0, ALU_ADD, 16'h0020, 16'h0003);
    set_req(1, ALU_ADD, 16'h0005, 16'h0005);
    req_valid = 2'b11;
    #1;
    n_cmp++;
    if (req_ready !== 2'b10) begin n_bad++; $display("FAIL mid_pre_grant: got %b want 10", req_ready); end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_data !== 16'h0000 || rsp_err !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_outputs: got rr=%b rv=%b data=%h err=%b busy=%b want all zero",
                        req_ready, rsp_valid, rsp_data, rsp_err, busy);
    end
    req_valid = 2'b00;
    tick();
    rst = 1'b1;
    m_ptr = 0;
    seen = 0;
    for (int h = 0; h < 4; h++) begin
      tick();
      if (rsp_valid !== 2'b00) seen = 1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL mid_no_rsp: got response after reset, want none"); end
    do_txn(2'b11, 0, 0, rr, rv, d, e, lat, st, tmo);
    n_cmp++;
    if (tmo !== 1'b0 || rr !== 2'b01 || d !== 16'h0023) begin
      n_bad++; $display("FAIL mid_regrant: got rr=%b data=%h tmo=%b want 01/0023/0", rr, d, tmo);
    end
  endtask

  task automatic test_random();
    logic [1:0] rr, rv; logic [15:0] d; logic e, st; int lat; bit tmo;
    logic [1:0] vmask;
    logic [3:0] op[2];
    logic [15:0] a[2], b[2];
    logic [16:0] r;
    logic [15:0] xd;
    logic xe;
    int g, hold;
    apply_reset();
    for (int k = 0; k < 40; k++) begin
      vmask = 2'($urandom_range(1, 3));
      for (int i = 0; i < 2; i++) begin
        op[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
        a[i]  = 16'($urandom);
        b[i]  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
        set_req(i, op[i], a[i], b[i]);
      end
      g = model_pick(vmask);
      r = model_op(op[g], a[g], b[g]);
      exp_q.push_back(r[15:0]);
      exp_err_q.push_back(r[16]);
      hold = $urandom_range(0, 3);
      do_txn(vmask, 0, hold, rr, rv, d, e, lat, st, tmo);
      xd = exp_q.pop_front();
      xe = exp_err_q.pop_front();
      n_cmp++;
      if (tmo !== 1'b0 || rr !== (g == 1 ? 2'b10 : 2'b01) || rv !== rr) begin
        n_bad++; $display("FAIL rand_grant[%0d]: got rr=%b rv=%b tmo=%b want requester %0d", k, rr, rv, tmo, g);
      end
      n_cmp++;
      if (d !== xd || e !== xe) begin
        n_bad++; $display("FAIL rand_data[%0d]: op=%h a=%h b=%h got %h err=%b want %h err=%b",
                          k, op[g], a[g], b[g], d, e, xd, xe);
      end
      n_cmp++;
      if (lat != 2 || st !== 1'b1) begin
        n_bad++; $display("FAIL rand_timing[%0d]: got latency=%0d stable=%b want 2/1", k, lat, st);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
